// File: rtl/ct_spsram_memshade_pkg.sv
// Shared types and helpers for the taint-shadowed single-port SRAM.
// grp_expand works at a fixed maximum width; callers size-cast in and out.
package ct_spsram_memshade_pkg;

    localparam int MAX_W = 1024;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } clr_state_e;

    // Replicate each write-enable bit across its group of i_grp data bits.
    function automatic logic [MAX_W-1:0] grp_expand(
        input logic [MAX_W-1:0] i_we,
        input logic [10:0]      i_grp
    );
        logic [MAX_W-1:0] v_out;
        logic [10:0]      v_idx;
        v_out = '0;
        for (logic [10:0] i = '0; i < 11'(MAX_W); i++) begin
            v_idx           = i / i_grp;
            v_out[i[9:0]]   = i_we[v_idx[9:0]];
        end
        return v_out;
    endfunction

endpackage

// File: rtl/ct_spsram_shadow_clr.sv
// Post-reset sweep that zeroes the taint array one entry per cycle.
// Holds the SRAM busy until the last entry has been cleared.
module ct_spsram_shadow_clr
    import ct_spsram_memshade_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    output logic                  o_busy,
    output logic                  o_clr_en,
    output logic [ADDR_WIDTH-1:0] o_clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    clr_state_e            r_state;
    clr_state_e            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_busy      = 1'b0;
        o_clr_en    = 1'b0;
        case (r_state)
            CLEAR: begin
                o_busy    = 1'b1;
                o_clr_en  = 1'b1;
                w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
            end
        endcase
    end

    assign o_clr_addr = r_cnt;

endmodule

// File: rtl/ct_spsram_memshade_param.sv
// Parametrised single-port SRAM with a same-shape taint shadow array.
// Taint follows writes and reads; the shadow is swept clean after reset.
module ct_spsram_memshade_param
    import ct_spsram_memshade_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 52,
    parameter int WE_WIDTH   = 52,
    parameter int OUT_REG    = 0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [ADDR_WIDTH-1:0] A_t0,
    input  logic                  CEN,
    input  logic                  CEN_t0,
    input  logic                  GWEN,
    input  logic                  GWEN_t0,
    input  logic [WE_WIDTH-1:0]   WEN,
    input  logic [WE_WIDTH-1:0]   WEN_t0,
    input  logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] D_t0,
    output logic [DATA_WIDTH-1:0] Q,
    output logic [DATA_WIDTH-1:0] Q_t0,
    output logic                  INIT_BUSY
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int GRP   = DATA_WIDTH / WE_WIDTH;

    generate
        if (DATA_WIDTH % WE_WIDTH != 0) begin : g_bad_we
            $error("DATA_WIDTH must be a multiple of WE_WIDTH");
        end
        if (DATA_WIDTH > MAX_W) begin : g_bad_dw
            $error("DATA_WIDTH exceeds grp_expand width");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_tnt [DEPTH];

    logic                  w_busy;
    logic                  w_clr_en;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_ct;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_idle_taint;
    logic [DATA_WIDTH-1:0] w_wmask;
    logic [DATA_WIDTH-1:0] w_tmask;
    logic [DATA_WIDTH-1:0] w_tnt_new;
    logic [DATA_WIDTH-1:0] r_q_p0;
    logic [DATA_WIDTH-1:0] r_qt_p0;

    ct_spsram_shadow_clr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr (
        .i_clk      (CLK),
        .i_rst      (RST),
        .o_busy     (w_busy),
        .o_clr_en   (w_clr_en),
        .o_clr_addr (w_clr_addr)
    );

    // Any taint on the control path taints every bit the access touches.
    assign w_ct         = (|A_t0) | CEN_t0 | GWEN_t0;
    assign w_wr         = ~w_busy & ~CEN & ~GWEN;
    assign w_rd         = ~w_busy & ~CEN & GWEN;
    assign w_idle_taint = ~w_busy & CEN & CEN_t0;

    assign w_wmask   = ~DATA_WIDTH'(grp_expand(MAX_W'(WEN), 11'(GRP)));
    assign w_tmask   = DATA_WIDTH'(grp_expand(MAX_W'(WEN_t0), 11'(GRP))) | {DATA_WIDTH{w_ct}};
    assign w_tnt_new = (w_wmask & D_t0) | (~w_wmask & r_tnt[A]) | w_tmask;

    always_ff @(posedge CLK) begin
        if (w_wr) begin
            r_mem[A] <= (D & w_wmask) | (r_mem[A] & ~w_wmask);
        end
    end

    // Sweep and functional writes are mutually exclusive since busy drops accesses.
    always_ff @(posedge CLK) begin
        if (w_clr_en) begin
            r_tnt[w_clr_addr] <= '0;
        end else if (w_wr) begin
            r_tnt[A] <= w_tnt_new;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_q_p0  <= '0;
            r_qt_p0 <= '0;
        end else if (w_rd) begin
            r_q_p0  <= r_mem[A];
            r_qt_p0 <= r_tnt[A] | {DATA_WIDTH{w_ct}};
        end else if (w_idle_taint) begin
            r_qt_p0 <= '1;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] r_q_p1;
            logic [DATA_WIDTH-1:0] r_qt_p1;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    r_q_p1  <= '0;
                    r_qt_p1 <= '0;
                end else begin
                    r_q_p1  <= r_q_p0;
                    r_qt_p1 <= r_qt_p0;
                end
            end
            assign Q    = r_q_p1;
            assign Q_t0 = r_qt_p1;
        end else begin : g_no_out_reg
            assign Q    = r_q_p0;
            assign Q_t0 = r_qt_p0;
        end
    endgenerate

    assign INIT_BUSY = w_busy;

endmodule

// File: tb/tb_ct_spsram_memshade_param.sv
// Scoreboard bench: one 4-group instance without output register and one
// 52-group instance with output register, driven by identical traffic.
module tb_ct_spsram_memshade_param;

    localparam int AW    = 9;
    localparam int DW    = 52;
    localparam int WW    = 4;
    localparam int GRP   = 13;
    localparam int DEPTH = 512;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [AW-1:0] A, A_t0;
    logic          CEN, CEN_t0, GWEN, GWEN_t0;
    logic [WW-1:0] WEN, WEN_t0;
    logic [DW-1:0] D, D_t0;
    logic [DW-1:0] wen_b, went_b;
    logic [DW-1:0] Qa, Qta, Qb, Qtb;
    logic          busy_a, busy_b;

    always #5 CLK = ~CLK;

    always_comb begin
        wen_b  = '0;
        went_b = '0;
        for (int g = 0; g < WW; g++) begin
            for (int b = 0; b < GRP; b++) begin
                wen_b[g*GRP+b]  = WEN[g];
                went_b[g*GRP+b] = WEN_t0[g];
            end
        end
    end

    ct_spsram_memshade_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .OUT_REG(0)) u_a (
        .CLK(CLK), .RST(RST), .A(A), .A_t0(A_t0), .CEN(CEN), .CEN_t0(CEN_t0),
        .GWEN(GWEN), .GWEN_t0(GWEN_t0), .WEN(WEN), .WEN_t0(WEN_t0), .D(D), .D_t0(D_t0),
        .Q(Qa), .Q_t0(Qta), .INIT_BUSY(busy_a));

    ct_spsram_memshade_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(DW), .OUT_REG(1)) u_b (
        .CLK(CLK), .RST(RST), .A(A), .A_t0(A_t0), .CEN(CEN), .CEN_t0(CEN_t0),
        .GWEN(GWEN), .GWEN_t0(GWEN_t0), .WEN(wen_b), .WEN_t0(went_b), .D(D), .D_t0(D_t0),
        .Q(Qb), .Q_t0(Qtb), .INIT_BUSY(busy_b));

    typedef struct {
        logic [DW-1:0] q;
        logic [DW-1:0] qt;
        logic          busy;
    } exp_t;

    exp_t          qa[$];
    exp_t          qb[$];
    logic [DW-1:0] mm [DEPTH];
    logic [DW-1:0] mt [DEPTH];
    logic          m_busy;
    int            m_cnt;
    logic [DW-1:0] m_q, m_qt;
    int            n_total = 0;
    int            n_bad   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one rising edge, evaluated on pre-edge inputs.
    task automatic model_edge();
        logic ct;
        int   k;
        ct = (|A_t0) | CEN_t0 | GWEN_t0;
        if (m_busy) begin
            mt[m_cnt] = '0;
            if (m_cnt == DEPTH - 1) m_busy = 1'b0;
            m_cnt++;
        end else if (!CEN) begin
            if (!GWEN) begin
                for (int g = 0; g < WW; g++) begin
                    for (int b = 0; b < GRP; b++) begin
                        k = g * GRP + b;
                        if (!WEN[g]) begin
                            mm[A][k] = D[k];
                            mt[A][k] = D_t0[k] | ct | WEN_t0[g];
                        end else begin
                            mt[A][k] = mt[A][k] | ct | WEN_t0[g];
                        end
                    end
                end
            end else begin
                m_q  = mm[A];
                m_qt = mt[A] | {DW{ct}};
            end
        end else if (CEN_t0) begin
            m_qt = '1;
        end
    endtask

    task automatic step();
        exp_t e, ea, eb;
        model_edge();
        e.q = m_q; e.qt = m_qt; e.busy = m_busy;
        qa.push_back(e);
        qb.push_back(e);
        @(posedge CLK);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("q_a", Qa, ea.q);
        chk("qt_a", Qta, ea.qt);
        chk("busy_a", DW'(busy_a), DW'(ea.busy));
        chk("q_b", Qb, eb.q);
        chk("qt_b", Qtb, eb.qt);
        chk("busy_b", DW'(busy_b), DW'(ea.busy));
    endtask

    task automatic set_idle();
        CEN = 1'b1; CEN_t0 = 1'b0; GWEN = 1'b1; GWEN_t0 = 1'b0;
        A_t0 = '0; WEN = '1; WEN_t0 = '0; D_t0 = '0;
    endtask

    task automatic do_reset();
        exp_t e;
        RST = 1'b1;
        #1;
        chk("rst_q_a", Qa, '0);
        chk("rst_qt_a", Qta, '0);
        chk("rst_busy_a", DW'(busy_a), DW'(1));
        chk("rst_q_b", Qb, '0);
        chk("rst_qt_b", Qtb, '0);
        chk("rst_busy_b", DW'(busy_b), DW'(1));
        @(posedge CLK);
        #1;
        RST = 1'b0;
        m_busy = 1'b1; m_cnt = 0; m_q = '0; m_qt = '0;
        qa.delete();
        qb.delete();
        e.q = '0; e.qt = '0; e.busy = 1'b1;
        qb.push_back(e);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [WW-1:0] wen,
                      input logic [DW-1:0] dt, input logic [WW-1:0] went);
        set_idle();
        CEN = 1'b0; GWEN = 1'b0; A = a; D = d; WEN = wen; D_t0 = dt; WEN_t0 = went;
        step();
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [AW-1:0] at);
        set_idle();
        CEN = 1'b0; GWEN = 1'b1; A = a; A_t0 = at;
        step();
    endtask

    task automatic idle_n(input int n);
        set_idle();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [63:0] r64;
        A = '0; D = '0;
        set_idle();
        #2;
        do_reset();
        idle_n(DEPTH + 3);

        for (int i = 0; i < 16; i++) begin
            r64 = {$urandom(), $urandom()};
            wr(AW'(i), r64[DW-1:0], '0, '0, '0);
        end

        // Clean write then read-after-write
        wr(9'd5, 52'h123, '0, '0, '0);
        rd(9'd5, '0);
        chk("clean_q", Qa, 52'h123);
        chk("clean_qt", Qta, '0);
        idle_n(2);

        // Partial tainted write: only group 0 written, with full data taint
        wr(9'd7, 52'hA_AAAA_AAAA_AAAA, 4'b1110, '1, '0);
        rd(9'd7, '0);
        chk("part_qt", Qta, 52'h0_0000_0000_1FFF);

        // Address taint on a clean entry, then untainted read
        rd(9'd5, 9'h001);
        chk("at_qt", Qta, '1);
        rd(9'd5, '0);
        chk("at_clear_qt", Qta, '0);

        // Idle with tainted chip enable forces output taint
        set_idle();
        CEN_t0 = 1'b1;
        step();
        idle_n(2);

        // Write-enable taint and control taint on writes
        wr(9'd9, 52'h5_5555_0000_1234, '0, '0, 4'b0100);
        rd(9'd9, '0);
        wr(9'd10, 52'h1, 4'b0011, '0, '0);
        set_idle();
        CEN = 1'b0; GWEN = 1'b0; GWEN_t0 = 1'b1; A = 9'd11; D = 52'h77; WEN = '0;
        step();
        rd(9'd10, '0);
        rd(9'd11, '0);
        idle_n(2);

        // Accesses during the sweep are dropped, including on the falling edge
        wr(9'd3, 52'h3_ABCD_EF01_2345, '0, '0, '0);
        idle_n(1);
        do_reset();
        idle_n(10);
        wr(9'd3, 52'hABC, '0, '1, '0);
        idle_n(DEPTH - 12);
        rd(9'd5, '0);
        rd(9'd5, '0);
        rd(9'd3, '0);
        chk("drop_q", Qa, 52'h3_ABCD_EF01_2345);
        chk("drop_qt", Qta, '0);
        idle_n(2);

        // Random traffic over the initialised address range
        for (int i = 0; i < 16; i++) begin
            r64 = {$urandom(), $urandom()};
            wr(AW'(i), r64[DW-1:0], '0, '0, '0);
        end
        for (int i = 0; i < 400; i++) begin
            set_idle();
            A       = AW'($urandom_range(0, 15));
            A_t0    = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(1, 511)) : '0;
            CEN     = ($urandom_range(0, 4) == 0);
            CEN_t0  = ($urandom_range(0, 7) == 0);
            GWEN    = $urandom_range(0, 1);
            GWEN_t0 = ($urandom_range(0, 9) == 0);
            WEN     = WW'($urandom_range(0, 15));
            WEN_t0  = ($urandom_range(0, 5) == 0) ? WW'($urandom_range(0, 15)) : '0;
            r64     = {$urandom(), $urandom()};
            D       = r64[DW-1:0];
            r64     = {$urandom(), $urandom()};
            D_t0    = ($urandom_range(0, 3) == 0) ? r64[DW-1:0] : '0;
            step();
        end
        idle_n(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
